// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request, HI/LO write and status signals of the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] portA;
    logic [WIDTH-1:0] portB;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ready;
    logic             busy;
    logic             done;
    logic             div_zero;
    modport master (output start, op, portA, portB, flush, wr_hi, wr_lo, wdata,
                    input hi, lo, ready, busy, done, div_zero);
    modport slave (input start, op, portA, portB, flush, wr_hi, wr_lo, wdata,
                   output hi, lo, ready, busy, done, div_zero);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply and divide into HI/LO, one bit per cycle.
module mul_div_unit #(parameter int WIDTH = 32) (
    input logic        CLK,
    input logic        RST,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_n, prod;
    logic [WIDTH-1:0] b_mag, a_in, b_in, quo, rem, rem_n, diff, hi_r, lo_r, hi_n, lo_n;
    logic [WIDTH:0] sum, shifted;
    logic is_div, q_neg, r_neg, bz, sgn, a_neg, b_neg, lt, accept, fin, done_r, dz_r;

    assign sgn    = !bus.op[0];
    assign a_neg  = sgn && bus.portA[WIDTH-1];
    assign b_neg  = sgn && bus.portB[WIDTH-1];
    assign a_in   = a_neg ? -bus.portA : bus.portA;
    assign b_in   = b_neg ? -bus.portB : bus.portB;
    assign accept = state == IDLE && bus.start && !bus.flush;
    assign fin    = state == FIX && !bus.flush;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        shifted = acc[2*WIDTH-1:WIDTH-1];
        lt      = shifted < {1'b0, b_mag};
        diff    = shifted[WIDTH-1:0] - b_mag;
        rem_n   = lt ? shifted[WIDTH-1:0] : diff;
        acc_n   = is_div ? {rem_n, acc[WIDTH-2:0], !lt} : {sum, acc[WIDTH-1:1]};
        quo     = acc[WIDTH-1:0];
        rem     = acc[2*WIDTH-1:WIDTH];
        prod    = q_neg ? -acc : acc;
        hi_n    = is_div ? (r_neg ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        lo_n    = is_div ? (bz ? '1 : (q_neg ? -quo : quo)) : prod[WIDTH-1:0];
    end

    always_comb begin
        state_n = bus.flush ? IDLE :
                  state == IDLE ? (bus.start ? CALC : IDLE) :
                  state == CALC ? (cnt == '0 ? FIX : CALC) : IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt    <= '0;
            acc    <= '0;
            b_mag  <= '0;
            is_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            bz     <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            done_r <= fin;
            if (accept) begin
                cnt    <= CW'(WIDTH);
                acc    <= {{WIDTH{1'b0}}, a_in};
                b_mag  <= b_in;
                is_div <= bus.op[1];
                q_neg  <= a_neg ^ b_neg;
                r_neg  <= a_neg;
                bz     <= bus.portB == '0;
            end else if (state == CALC && cnt != '0) begin
                cnt <= cnt - 1'b1;
                acc <= acc_n;
            end
            // completion write wins; direct writes only land while idle
            if (fin) begin
                hi_r <= hi_n;
                lo_r <= lo_n;
                dz_r <= is_div && bz;
            end else if (state == IDLE) begin
                if (bus.wr_hi) hi_r <= bus.wdata;
                if (bus.wr_lo) lo_r <= bus.wdata;
            end
        end
    end

    assign bus.hi       = hi_r;
    assign bus.lo       = lo_r;
    assign bus.ready    = state == IDLE;
    assign bus.busy     = state != IDLE;
    assign bus.done     = done_r;
    assign bus.div_zero = dz_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with a queued scoreboard checked on each done pulse.
module tb_mul_div_unit;
    localparam int W = 32;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    mul_div_unit_if #(.WIDTH(W)) bus();
    mul_div_unit #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_fail = 0;
    logic [W-1:0] last_hi = '0;
    logic [W-1:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.done) begin
            if (q.size() == 0) check("spurious_done", 64'd1, 64'd0);
            else begin
                exp_t e;
                e = q.pop_front();
                check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!bus.done && n < 50);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        bus.op = op; bus.portA = a; bus.portB = b; bus.start = 1'b1;
        @(posedge CLK); #1;
        bus.start = 1'b0;
        check("accepted", {63'd0, bus.busy}, 64'd1);
        q.push_back('{ehi, elo, edz});
        last_hi = ehi; last_lo = elo;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz);
        int n;
        issue(op, a, b, ehi, elo, edz);
        wait_done(n);
        check("latency", 64'(n), 64'(W + 2));
        @(posedge CLK); #1;
        check("done_pulse", {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.start = 0; bus.op = 0; bus.portA = 0; bus.portB = 0;
        bus.flush = 0; bus.wr_hi = 0; bus.wr_lo = 0; bus.wdata = 0;
        #12;
        check("rst_hi", {32'd0, bus.hi}, 64'd0);
        check("rst_lo", {32'd0, bus.lo}, 64'd0);
        check("rst_ready", {63'd0, bus.ready}, 64'd1);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dz", {63'd0, bus.div_zero}, 64'd0);
        @(negedge CLK); RST = 0;

        do_op(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        do_op(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        do_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        do_op(2'b11, 32'h00000010, 32'h00000000, 32'h00000010, 32'hFFFFFFFF, 1'b1);
        do_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
        do_op(2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
        do_op(2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

        // flush mid-operation, with an ignored LO write while busy
        bus.op = 2'b01; bus.portA = 5; bus.portB = 5; bus.start = 1;
        @(posedge CLK); #1;
        bus.start = 0; bus.wr_lo = 1; bus.wdata = 32'h1234;
        repeat (10) @(posedge CLK);
        #1 bus.wr_lo = 0;
        check("busy_wr_lo", {32'd0, bus.lo}, {32'd0, last_lo});
        bus.flush = 1;
        @(posedge CLK); #1;
        bus.flush = 0;
        check("flush_ready", {63'd0, bus.ready}, 64'd1);
        repeat (40) @(posedge CLK);
        #1;
        check("flush_hi", {32'd0, bus.hi}, {32'd0, last_hi});
        check("flush_lo", {32'd0, bus.lo}, {32'd0, last_lo});

        // flush beats start in the same cycle
        bus.flush = 1; bus.start = 1;
        @(posedge CLK); #1;
        bus.flush = 0; bus.start = 0;
        check("flush_over_start", {63'd0, bus.ready}, 64'd1);

        // direct writes while idle, one combined with start
        bus.wr_hi = 1; bus.wdata = 32'hAAAA5555;
        @(posedge CLK); #1;
        bus.wr_hi = 0;
        check("idle_wr_hi", {32'd0, bus.hi}, 64'hAAAA5555);
        bus.wr_lo = 1; bus.wdata = 32'h55;
        bus.op = 2'b01; bus.portA = 3; bus.portB = 4; bus.start = 1;
        @(posedge CLK); #1;
        bus.wr_lo = 0; bus.start = 0;
        check("wr_lo_with_start", {32'd0, bus.lo}, 64'h55);
        check("wr_start_busy", {63'd0, bus.busy}, 64'd1);
        q.push_back('{32'd0, 32'd12, 1'b0});
        wait_done(n);
        check("latency_wr", 64'(n), 64'(W + 2));

        // back-to-back: second start presented in the done cycle
        issue(2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 1'b0);
        wait_done(n);
        check("latency_b2b_1", 64'(n), 64'(W + 2));
        bus.op = 2'b00; bus.portA = 32'hFFFFFFFF; bus.portB = 32'd10; bus.start = 1;
        q.push_back('{32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0});
        @(posedge CLK); #1;
        bus.start = 0;
        check("b2b_accept", {63'd0, bus.busy}, 64'd1);
        wait_done(n);
        check("latency_b2b_2", 64'(n), 64'(W + 2));

        // reset pulse mid-CALC discards the operation
        @(posedge CLK); #1;
        bus.op = 2'b01; bus.portA = 7; bus.portB = 7; bus.start = 1;
        @(posedge CLK); #1;
        bus.start = 0;
        repeat (10) @(posedge CLK);
        #1 RST = 1;
        #1;
        check("midrst_hi", {32'd0, bus.hi}, 64'd0);
        check("midrst_lo", {32'd0, bus.lo}, 64'd0);
        check("midrst_ready", {63'd0, bus.ready}, 64'd1);
        @(negedge CLK); RST = 0;
        repeat (40) @(posedge CLK);
        #1;
        check("postrst_hi", {32'd0, bus.hi}, 64'd0);
        check("postrst_lo", {32'd0, bus.lo}, 64'd0);
        do_op(2'b00, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0);

        repeat (2) @(posedge CLK);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
